redmule_x_pingpong_buffer: RTL and testbench
============================================

# redmule_x_pingpong_buffer

Double-banked, parametrised X-operand buffer for the RedMulE datapath. It accepts X rows from the streamer over a valid/ready handshake into one bank while the other bank streams depth slices of all W rows into the array. Per-tile row and column leftovers are handled with zero masking. An optional replay mode re-streams a stored tile several times before releasing its bank.

## Interface
- DW, 256: input beat width in bits; must be a multiple of H*BITW.
- BITW, 16: element width in bits.
- H, 4: elements per slice per row (array height).
- W, 12: rows per tile (array width).
- D (derived), DW/(H*BITW): slices per row.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous and active-low.
- clear_i  in  1  synchronous clear of all state.
- cfg_rows_i  in  $clog2(W)+1  valid rows per tile; 0 means W.
- cfg_cols_i  in  $clog2(H*D)+1  valid elements per row; 0 means H*D.
- cfg_reps_i  in  8  stream count per tile; 0 treated as 1.
- in_data_i  in  DW  one X row; element e is in_data_i[e*BITW +: BITW].
- in_valid_i  in  1  row beat valid.
- in_ready_o  out  1  row beat accepted when high with in_valid_i.
- shift_i  in  1  consumer advance to the next slice.
- out_valid_o  out  1  x_o holds a valid slice.
- x_o  out  W*H*BITW  [W-1:0][H-1:0][BITW-1:0] current slice.
- out_last_o  out  1  current slice is the final slice of the final replay.
- full_o  out  1  both banks FULL.
- empty_o  out  1  both banks EMPTY.

## Operation
- Each bank has states EMPTY -> FILLING -> FULL -> EMPTY.
- The fill bank pointer wr_bank and the drain bank pointer rd_bank each toggle after their bank completes.
- First accepted beat into an EMPTY bank: the bank latches cfg_rows_i, cfg_cols_i and cfg_reps_i, then goes to FILLING. These settings stay fixed for that tile.
- Each accepted beat writes row wr_row. Element e is stored as 0 when e >= cols; otherwise it is stored from in_data_i. wr_row then increments.
- After row rows-1 is accepted, the bank goes to FULL, wr_row resets to 0 and wr_bank toggles.
- in_ready_o = 1 when bank[wr_bank] is not FULL.
- out_valid_o = 1 when bank[rd_bank] is FULL.
- x_o[w] = slice rd_slice of row w. Rows with w >= rows output 0. x_o is all zero when out_valid_o = 0.
- Slice count S = ceil(cols/H).
- shift_i with out_valid_o: rd_slice increments.
  - At rd_slice = S-1, rd_slice wraps to 0 and rd_rep increments.
  - At rd_rep = reps-1 and rd_slice = S-1, the bank goes EMPTY and rd_bank toggles.
  - out_last_o = out_valid_o & (rd_slice = S-1) & (rd_rep = reps-1).
- shift_i without out_valid_o is ignored.
- Fill and drain on different banks in the same cycle are independent.
- A bank released in cycle t is fillable from cycle t+1. There is no same-cycle bypass.
- clear_i has priority over in_valid_i and shift_i in the same cycle; any beat presented that cycle is dropped. clear_i sets all banks EMPTY and all pointers and counters to 0. Storage contents are don't-care because they are masked.

## Timing
- Reset values: in_ready_o=1, out_valid_o=0, x_o=0, out_last_o=0, full_o=0, empty_o=1. All pointers and counters are 0 and both banks are EMPTY.
- Write latency: the last row is accepted at edge t; out_valid_o is high from cycle t+1 if that bank is rd_bank.
- Slice advance: shift_i at edge t means x_o shows the next slice from cycle t+1.
- All outputs are derived from registers plus combinational muxing. No output depends combinationally on in_valid_i or shift_i.
- Reset asserted mid-tile returns all state to reset values immediately; partial tiles are discarded.

## Configuration
- REDMULE_XBUF_REPLAY_EN defined:
  - cfg_reps_i is latched per bank.
  - Each tile is streamed reps times before its bank is released.
- REDMULE_XBUF_REPLAY_EN undefined:
  - cfg_reps_i is ignored and reps is fixed at 1.
  - The rd_rep counter is not instantiated.
  - out_last_o = out_valid_o & (rd_slice = S-1).
- The port list is identical in both builds.

## Test plan
- Full tile, defaults (W=12, H=4, D=4), rows=0, cols=0: push 12 rows with element value = row*16 + e.
  - out_valid_o rises 1 cycle after the 12th accept.
  - 4 shifts yield x_o[w][h] = w*16 + s*4 + h for slice s.
  - out_last_o is high on slice 3; afterwards the bank is EMPTY.
- Leftovers, rows=5, cols=6: S=2.
  - Rows 5..11 read 0.
  - Slice 1 elements h=2,3 read 0.
  - The bank is released after 2 shifts.
- Ping-pong with in_valid_i held high, no shift:
  - in_ready_o drops after 24 accepts and full_o=1.
  - One full drain reasserts in_ready_o the cycle after release.
  - Drain order is tile A then tile B.
- Replay (macro on), reps=3:
  - 12 shifts for S=4.
  - out_last_o is high only on the 12th slice; data repeats identically.
  - With the macro off, the same stimulus releases the bank after 4 shifts.
- clear_i asserted together with in_valid_i and shift_i mid-tile:
  - The next cycle shows empty_o=1, out_valid_o=0, in_ready_o=1.
  - A fresh tile then loads into bank 0.
- rst_ni pulsed low while tile B is filling and tile A is draining: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/redmule_x_pingpong_buffer_if.sv
// Row-in / slice-out handshake bundle of the RedMulE X ping-pong buffer.
interface redmule_x_pingpong_buffer_if #(
  parameter int unsigned DW   = 256,
  parameter int unsigned BITW = 16,
  parameter int unsigned H    = 4,
  parameter int unsigned W    = 12
);
  logic [DW-1:0]                 in_data_i;
  logic                          in_valid_i;
  logic                          in_ready_o;
  logic                          shift_i;
  logic                          out_valid_o;
  logic [W-1:0][H-1:0][BITW-1:0] x_o;
  logic                          out_last_o;

  // Streamer + array side
  modport master (
    output in_data_i, in_valid_i, shift_i,
    input  in_ready_o, out_valid_o, x_o, out_last_o
  );

  // Buffer side
  modport slave (
    input  in_data_i, in_valid_i, shift_i,
    output in_ready_o, out_valid_o, x_o, out_last_o
  );
endinterface

// File: rtl/redmule_x_pingpong_buffer.sv
// Double-banked X-operand buffer: fills one bank with rows while the other streams slices.
// Optional tile replay is enabled by defining REDMULE_XBUF_REPLAY_EN.
module redmule_x_pingpong_buffer #(
  parameter int unsigned DW   = 256,
  parameter int unsigned BITW = 16,
  parameter int unsigned H    = 4,
  parameter int unsigned W    = 12
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic [$clog2(W):0]        cfg_rows_i,
  input  logic [$clog2(DW/BITW):0]  cfg_cols_i,
  input  logic [7:0]                cfg_reps_i,
  redmule_x_pingpong_buffer_if.slave bus,
  output logic                      full_o,
  output logic                      empty_o
);

  localparam int unsigned D   = DW / (H * BITW);
  localparam int unsigned E   = H * D;
  localparam int unsigned RW  = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned NRW = $clog2(W + 1);
  localparam int unsigned NCW = $clog2(E + 1);
  localparam int unsigned SW  = (D > 1) ? $clog2(D) : 1;
  localparam int unsigned EW  = (E > 1) ? $clog2(E) : 1;

  typedef enum logic [1:0] {BANK_EMPTY, BANK_FILLING, BANK_FULL} bank_state_e;

  bank_state_e     r_state [2];
  logic [NRW-1:0]  r_rows  [2];
  logic [NCW-1:0]  r_cols  [2];
  logic            r_wr_bank;
  logic            r_rd_bank;
  logic [RW-1:0]   r_wr_row;
  logic [SW-1:0]   r_rd_slice;
  logic [BITW-1:0] r_mem   [2][W][E];

  logic [NRW-1:0]  w_cfg_rows;
  logic [NCW-1:0]  w_cfg_cols;
  logic [NRW-1:0]  w_wr_rows;
  logic [NCW-1:0]  w_wr_cols;
  logic [NCW-1:0]  w_nslices;
  logic [EW-1:0]   w_base;
  logic            w_in_ready;
  logic            w_out_valid;
  logic            w_accept;
  logic            w_wr_last;
  logic            w_shift;
  logic            w_slice_last;
  logic            w_rep_last;
  logic            w_first_beat;

`ifdef REDMULE_XBUF_REPLAY_EN
  logic [7:0] r_reps [2];
  logic [7:0] r_rd_rep;
  logic [7:0] w_cfg_reps;

  assign w_cfg_reps = (cfg_reps_i == 8'd0) ? 8'd1 : cfg_reps_i;
  assign w_rep_last = (r_rd_rep + 8'd1) == r_reps[r_rd_bank];
`else
  logic w_unused_reps;

  assign w_unused_reps = ^cfg_reps_i;
  assign w_rep_last    = 1'b1;
`endif

  // Zero or out-of-range settings collapse to the full tile size
  always_comb begin
    w_cfg_rows = NRW'(W);
    if (cfg_rows_i != '0 && 32'(cfg_rows_i) < W) w_cfg_rows = NRW'(cfg_rows_i);
    w_cfg_cols = NCW'(E);
    if (cfg_cols_i != '0 && 32'(cfg_cols_i) < E) w_cfg_cols = NCW'(cfg_cols_i);
  end

  assign w_first_beat = (r_state[r_wr_bank] == BANK_EMPTY);
  assign w_wr_rows    = w_first_beat ? w_cfg_rows : r_rows[r_wr_bank];
  assign w_wr_cols    = w_first_beat ? w_cfg_cols : r_cols[r_wr_bank];
  assign w_in_ready   = (r_state[r_wr_bank] != BANK_FULL);
  assign w_accept     = bus.in_valid_i & w_in_ready & ~clear_i;
  assign w_wr_last    = (32'(r_wr_row) + 32'd1) == 32'(w_wr_rows);

  assign w_out_valid  = (r_state[r_rd_bank] == BANK_FULL);
  assign w_nslices    = NCW'((32'(r_cols[r_rd_bank]) + H - 1) / H);
  assign w_slice_last = (32'(r_rd_slice) + 32'd1) == 32'(w_nslices);
  assign w_shift      = bus.shift_i & w_out_valid & ~clear_i;

  // Bank lifecycle, fill/drain pointers and tile settings
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < 2; b++) begin
        r_state[b] <= BANK_EMPTY;
        r_rows[b]  <= '0;
        r_cols[b]  <= '0;
`ifdef REDMULE_XBUF_REPLAY_EN
        r_reps[b]  <= '0;
`endif
      end
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_wr_row   <= '0;
      r_rd_slice <= '0;
`ifdef REDMULE_XBUF_REPLAY_EN
      r_rd_rep   <= '0;
`endif
    end else if (clear_i) begin
      for (int b = 0; b < 2; b++) begin
        r_state[b] <= BANK_EMPTY;
        r_rows[b]  <= '0;
        r_cols[b]  <= '0;
`ifdef REDMULE_XBUF_REPLAY_EN
        r_reps[b]  <= '0;
`endif
      end
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_wr_row   <= '0;
      r_rd_slice <= '0;
`ifdef REDMULE_XBUF_REPLAY_EN
      r_rd_rep   <= '0;
`endif
    end else begin
      if (w_accept) begin
        if (w_first_beat) begin
          r_rows[r_wr_bank] <= w_cfg_rows;
          r_cols[r_wr_bank] <= w_cfg_cols;
`ifdef REDMULE_XBUF_REPLAY_EN
          r_reps[r_wr_bank] <= w_cfg_reps;
`endif
        end
        if (w_wr_last) begin
          r_state[r_wr_bank] <= BANK_FULL;
          r_wr_row           <= '0;
          r_wr_bank          <= ~r_wr_bank;
        end else begin
          r_state[r_wr_bank] <= BANK_FILLING;
          r_wr_row           <= r_wr_row + 1'b1;
        end
      end
      if (w_shift) begin
        if (w_slice_last) begin
          r_rd_slice <= '0;
          if (w_rep_last) begin
            r_state[r_rd_bank] <= BANK_EMPTY;
            r_rd_bank          <= ~r_rd_bank;
          end
`ifdef REDMULE_XBUF_REPLAY_EN
          r_rd_rep <= w_rep_last ? 8'd0 : r_rd_rep + 8'd1;
`endif
        end else begin
          r_rd_slice <= r_rd_slice + 1'b1;
        end
      end
    end
  end

  // Row storage; columns beyond the tile width are stored as zero
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      for (int e = 0; e < E; e++) begin
        r_mem[r_wr_bank][r_wr_row][e] <= (e < 32'(w_wr_cols)) ? bus.in_data_i[e*BITW +: BITW] : '0;
      end
    end
  end

  assign w_base = EW'(r_rd_slice) * EW'(H);

  // Slice read mux; rows beyond the tile height read as zero
  for (genvar gw = 0; gw < W; gw++) begin : g_row
    localparam logic [NRW-1:0] ROW = NRW'(gw);
    for (genvar gh = 0; gh < H; gh++) begin : g_elem
      localparam logic [EW-1:0] HOFF = EW'(gh);
      assign bus.x_o[gw][gh] = (w_out_valid && (ROW < r_rows[r_rd_bank]))
                             ? r_mem[r_rd_bank][gw][w_base + HOFF] : '0;
    end
  end

  assign bus.in_ready_o  = w_in_ready;
  assign bus.out_valid_o = w_out_valid;
  assign bus.out_last_o  = w_out_valid & w_slice_last & w_rep_last;
  assign full_o          = (r_state[0] == BANK_FULL)  & (r_state[1] == BANK_FULL);
  assign empty_o         = (r_state[0] == BANK_EMPTY) & (r_state[1] == BANK_EMPTY);

endmodule

// File: tb/tb_redmule_x_pingpong_buffer.sv
// Directed bench for the X ping-pong buffer with a slice scoreboard.
module tb_redmule_x_pingpong_buffer;
  localparam int unsigned DW   = 256;
  localparam int unsigned BITW = 16;
  localparam int unsigned H    = 4;
  localparam int unsigned W    = 12;
  localparam int unsigned E    = DW / BITW;
  localparam int unsigned SLW  = W * H * BITW;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic [4:0] cfg_rows = '0;
  logic [4:0] cfg_cols = '0;
  logic [7:0] cfg_reps = '0;
  logic       full;
  logic       empty;

  redmule_x_pingpong_buffer_if #(.DW(DW), .BITW(BITW), .H(H), .W(W)) bus ();

  redmule_x_pingpong_buffer #(.DW(DW), .BITW(BITW), .H(H), .W(W)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .clear_i    (clear),
    .cfg_rows_i (cfg_rows),
    .cfg_cols_i (cfg_cols),
    .cfg_reps_i (cfg_reps),
    .bus        (bus.slave),
    .full_o     (full),
    .empty_o    (empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [SLW-1:0] x;
    logic           last;
  } exp_t;

  exp_t            exp_q[$];
  int              total = 0;
  int              bad = 0;
  logic [BITW-1:0] tile [W][E];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkx(input string tag, input logic [SLW-1:0] obs, input logic [SLW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // base < 0 selects random element values
  task automatic fill_tile(input int base);
    for (int r = 0; r < W; r++)
      for (int e = 0; e < E; e++)
        tile[r][e] = (base < 0) ? BITW'($urandom) : BITW'(base + r * 16 + e);
  endtask

  task automatic send_rows(input int first, input int n, input bit hold);
    for (int r = first; r < first + n; r++) begin
      int waited = 0;
      for (int e = 0; e < E; e++) bus.in_data_i[e*BITW +: BITW] = tile[r][e];
      bus.in_valid_i = 1'b1;
      while (bus.in_ready_o !== 1'b1) begin
        @(negedge clk);
        waited++;
        if (waited > 200) begin
          total++;
          bad++;
          $error("FAIL ready_timeout row=%0d observed=0 expected=1", r);
          bus.in_valid_i = 1'b0;
          return;
        end
      end
      @(negedge clk);
    end
    if (!hold) bus.in_valid_i = 1'b0;
  endtask

  // Reference slices of the current tile, queued in drain order
  task automatic push_model(input int rows_cfg, input int cols_cfg, input int reps_cfg);
    int rows, cols, reps, ns;
    exp_t ex;
    rows = (rows_cfg == 0 || rows_cfg > W) ? W : rows_cfg;
    cols = (cols_cfg == 0 || cols_cfg > E) ? E : cols_cfg;
`ifdef REDMULE_XBUF_REPLAY_EN
    reps = (reps_cfg == 0) ? 1 : reps_cfg;
`else
    reps = 1;
`endif
    ns = (cols + H - 1) / H;
    for (int rp = 0; rp < reps; rp++)
      for (int s = 0; s < ns; s++) begin
        ex.x = '0;
        for (int w = 0; w < rows; w++)
          for (int h = 0; h < H; h++)
            if (s * H + h < cols) ex.x[(w*H + h)*BITW +: BITW] = tile[w][s*H + h];
        ex.last = (s == ns - 1) && (rp == reps - 1);
        exp_q.push_back(ex);
      end
  endtask

  task automatic shift_chk(input string tag);
    exp_t ex;
    chk1({tag, "_valid"}, bus.out_valid_o, 1'b1);
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end else begin
      ex = exp_q.pop_front();
      chkx({tag, "_x"}, bus.x_o, ex.x);
      chk1({tag, "_last"}, bus.out_last_o, ex.last);
    end
    bus.shift_i = 1'b1;
    @(negedge clk);
    bus.shift_i = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, "_ready"}, bus.in_ready_o, 1'b1);
    chk1({tag, "_valid"}, bus.out_valid_o, 1'b0);
    chkx({tag, "_x"}, bus.x_o, '0);
    chk1({tag, "_last"}, bus.out_last_o, 1'b0);
    chk1({tag, "_full"}, full, 1'b0);
    chk1({tag, "_empty"}, empty, 1'b1);
  endtask

  initial begin
    int nshift;
    bus.in_data_i  = '0;
    bus.in_valid_i = 1'b0;
    bus.shift_i    = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Shift with nothing valid must be ignored
    bus.shift_i = 1'b1;
    @(negedge clk);
    bus.shift_i = 1'b0;
    chk1("idle_shift_valid", bus.out_valid_o, 1'b0);

    // Full tile with default settings
    cfg_rows = 5'd0; cfg_cols = 5'd0; cfg_reps = 8'd1;
    fill_tile(0);
    send_rows(0, 11, 1'b1);
    chk1("full_pre_valid", bus.out_valid_o, 1'b0);
    send_rows(11, 1, 1'b0);
    push_model(0, 0, 1);
    for (int s = 0; s < 4; s++) shift_chk("full");
    chk1("full_empty", empty, 1'b1);
    chk1("full_valid_after", bus.out_valid_o, 1'b0);

    // Row and column leftovers
    cfg_rows = 5'd5; cfg_cols = 5'd6;
    fill_tile(-1);
    send_rows(0, 5, 1'b0);
    push_model(5, 6, 1);
    shift_chk("left0");
    shift_chk("left1");
    chk1("left_empty", empty, 1'b1);

    // Ping-pong: two tiles back to back with valid held high
    cfg_rows = 5'd0; cfg_cols = 5'd0;
    fill_tile(16'h100);
    send_rows(0, 12, 1'b1);
    push_model(0, 0, 1);
    fill_tile(-1);
    send_rows(0, 12, 1'b1);
    push_model(0, 0, 1);
    chk1("pp_ready_low", bus.in_ready_o, 1'b0);
    chk1("pp_full", full, 1'b1);
    @(negedge clk);
    chk1("pp_ready_hold", bus.in_ready_o, 1'b0);
    bus.in_valid_i = 1'b0;
    for (int s = 0; s < 3; s++) shift_chk("ppA");
    chk1("pp_ready_before_rel", bus.in_ready_o, 1'b0);
    shift_chk("ppA");
    chk1("pp_ready_after_rel", bus.in_ready_o, 1'b1);
    chk1("pp_full_after_rel", full, 1'b0);
    for (int s = 0; s < 4; s++) shift_chk("ppB");
    chk1("pp_empty", empty, 1'b1);

    // Replay: three streams when enabled, one otherwise
    cfg_reps = 8'd3;
    fill_tile(-1);
    send_rows(0, 12, 1'b0);
    push_model(0, 0, 3);
`ifdef REDMULE_XBUF_REPLAY_EN
    nshift = 12;
`else
    nshift = 4;
`endif
    for (int s = 0; s < nshift; s++) shift_chk("rep");
    chk1("rep_empty", empty, 1'b1);
    cfg_reps = 8'd1;

    // Clear together with a beat and a shift mid-tile
    fill_tile(-1);
    send_rows(0, 12, 1'b0);
    send_rows(0, 3, 1'b0);
    bus.in_valid_i = 1'b1;
    bus.shift_i    = 1'b1;
    clear          = 1'b1;
    @(negedge clk);
    clear          = 1'b0;
    bus.shift_i    = 1'b0;
    bus.in_valid_i = 1'b0;
    chk_reset_outputs("clr");
    exp_q.delete();
    cfg_rows = 5'd7; cfg_cols = 5'd10;
    fill_tile(-1);
    send_rows(0, 7, 1'b0);
    push_model(7, 10, 1);
    for (int s = 0; s < 3; s++) shift_chk("clr_fresh");
    chk1("clr_fresh_empty", empty, 1'b1);

    // Asynchronous reset while A drains and B fills
    cfg_rows = 5'd0; cfg_cols = 5'd0;
    fill_tile(-1);
    send_rows(0, 12, 1'b0);
    push_model(0, 0, 1);
    shift_chk("arst_a");
    fill_tile(-1);
    send_rows(0, 5, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("arst");
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    cfg_rows = 5'd1; cfg_cols = 5'd1;
    fill_tile(-1);
    send_rows(0, 1, 1'b0);
    push_model(1, 1, 1);
    shift_chk("arst_post");
    chk1("arst_post_empty", empty, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
